// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared half-precision types, constants and divider state encoding
package fpu_types_pkg;
   localparam int HALF_FLOAT_W    = 16;
   localparam int HALF_EXPONENT_W = 5;
   localparam int HALF_FRACTION_W = 10;
   typedef logic [HALF_EXPONENT_W-1:0] exp_t;
   typedef logic [HALF_FRACTION_W-1:0] mant_t;
   localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO     = 16'h0000;
   localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN     = 16'hFFFF;
   localparam logic [HALF_FLOAT_W-1:0] HALF_SNAN_OUT = 16'hFDFF;
   localparam logic [HALF_FLOAT_W-2:0] HALF_INF      = 15'h7C00;
   localparam int QBITS          = 12;
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_DIV_ZERO  = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_NORM, S_DONE} div_state_t;
endpackage

// File: rtl/half_lzc_10.sv
// half_lzc_10: leading-zero count of a 10-bit fraction, 10 when all zero
module half_lzc_10
   import fpu_types_pkg::*;
(
   input  mant_t      mant,
   output logic [3:0] count
);
   // scan upward so the most significant set bit decides the count
   always_comb begin
      count = 4'd10;
      for (int i = 0; i < HALF_FRACTION_W; i++)
         if (mant[i]) count = 4'(HALF_FRACTION_W - 1 - i);
   end
endmodule

// File: rtl/float_div_16bit_seq.sv
// float_div_16bit_seq: iterative half-precision divider, one quotient bit per cycle, truncating
module float_div_16bit_seq
   import fpu_types_pkg::*;
(
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    start,
   input  logic [HALF_FLOAT_W-1:0] dividend,
   input  logic [HALF_FLOAT_W-1:0] divisor,
   output logic                    busy,
   output logic                    done,
   output logic [HALF_FLOAT_W-1:0] quotient,
   output logic [3:0]              flags
);
   div_state_t        state, next_state;
   logic [15:0]       op_a, op_b, res, sp_res, nr_res;
   logic [3:0]        res_flags, sp_flags, nr_flags, lza, lzb, cnt;
   logic signed [6:0] exp_r, xa, xb, exp_calc, n_exp;
   logic [11:0]       rem, trial;
   logic [10:0]       div_m, sig_a, sig_b, sig, shifted;
   logic [QBITS-1:0]  q;
   logic [9:0]        frac;
   logic [4:0]        n_sh;
   exp_t              ea, eb;
   mant_t             ma, mb;
   logic              sgn, sp_hit, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inexact, lost;

   assign ea    = op_a[14:10];
   assign eb    = op_b[14:10];
   assign ma    = op_a[9:0];
   assign mb    = op_b[9:0];
   assign sgn   = op_a[15] ^ op_b[15];
   assign busy  = (state != S_IDLE);
   assign trial = rem - {1'b0, div_m};

   half_lzc_10 u_lza (.mant(ma), .count(lza));
   half_lzc_10 u_lzb (.mant(mb), .count(lzb));

   // classify operands, resolve special cases and prepare normalised significands
   always_comb begin
      a_nan    = (ea == '1) && (ma != '0);
      b_nan    = (eb == '1) && (mb != '0);
      a_inf    = (ea == '1) && (ma == '0);
      b_inf    = (eb == '1) && (mb == '0);
      a_zero   = (ea == '0) && (ma == '0);
      b_zero   = (eb == '0) && (mb == '0);
      sig_a    = (ea == '0) ? 11'({1'b0, ma} << (lza + 4'd1)) : {1'b1, ma};
      sig_b    = (eb == '0) ? 11'({1'b0, mb} << (lzb + 4'd1)) : {1'b1, mb};
      xa       = (ea == '0) ? 7'sd0 - 7'(lza) : 7'(ea);
      xb       = (eb == '0) ? 7'sd0 - 7'(lzb) : 7'(eb);
      exp_calc = xa - xb + 7'sd15;
      sp_hit   = 1'b1;
      sp_res   = {sgn, HALF_INF};
      sp_flags = '0;
      if ((a_nan && ma[9]) || (b_nan && mb[9]))
         sp_res = HALF_QNAN;
      else if (a_nan || b_nan) begin
         sp_res = HALF_SNAN_OUT;
         sp_flags[FLAG_INVALID] = 1'b1;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_res = HALF_QNAN;
         sp_flags[FLAG_INVALID] = 1'b1;
      end else if (b_zero && !a_inf)
         sp_flags[FLAG_DIV_ZERO] = 1'b1;
      else if (a_zero || b_inf)
         sp_res = {sgn, 15'h0000};
      else
         sp_hit = a_inf;
   end

   // normalise the raw quotient, then saturate to inf or denormalise towards zero
   always_comb begin
      frac     = q[11] ? q[10:1] : q[9:0];
      n_exp    = q[11] ? exp_r : exp_r - 7'sd1;
      n_sh     = 5'd1 - n_exp[4:0];
      sig      = {1'b1, frac};
      shifted  = sig >> n_sh;
      lost     = (shifted << n_sh) != sig;
      inexact  = (rem != '0) || (q[11] && q[0]);
      nr_res   = {sgn, n_exp[4:0], frac};
      nr_flags = '0;
      if (n_exp >= 7'sd31) begin
         nr_res = {sgn, HALF_INF};
         nr_flags[FLAG_OVERFLOW] = 1'b1;
      end else if (n_exp <= 7'sd0) begin
         nr_res = {sgn, 5'd0, shifted[9:0]};
         nr_flags[FLAG_UNDERFLOW] = inexact || lost;
      end
   end

   // sequence IDLE -> PREP -> DIV -> NORM -> DONE, with specials skipping to DONE
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  next_state = start ? S_PREP : S_IDLE;
         S_PREP:  next_state = sp_hit ? S_DONE : S_DIV;
         S_DIV:   next_state = (cnt == '0) ? S_NORM : S_DIV;
         S_NORM:  next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) state <= S_IDLE;
      else       state <= next_state;

   // datapath: operand latch, restoring division steps and result registers
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         op_a      <= HALF_ZERO;
         op_b      <= HALF_ZERO;
         rem       <= '0;
         div_m     <= '0;
         cnt       <= '0;
         q         <= '0;
         exp_r     <= '0;
         res       <= HALF_ZERO;
         res_flags <= '0;
         quotient  <= HALF_ZERO;
         flags     <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               op_a <= dividend;
               op_b <= divisor;
            end
            S_PREP: begin
               rem       <= {1'b0, sig_a};
               div_m     <= sig_b;
               cnt       <= 4'(QBITS - 1);
               q         <= '0;
               exp_r     <= exp_calc;
               res       <= sp_res;
               res_flags <= sp_flags;
            end
            S_DIV: begin
               rem <= trial[11] ? {rem[10:0], 1'b0} : {trial[10:0], 1'b0};
               q   <= {q[QBITS-2:0], ~trial[11]};
               cnt <= cnt - 4'd1;
            end
            S_NORM: begin
               res       <= nr_res;
               res_flags <= nr_flags;
            end
            S_DONE: begin
               quotient <= res;
               flags    <= res_flags;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_float_div_16bit_seq.sv
// tb_float_div_16bit_seq: directed and random checks of the divider against an exact-arithmetic model
module tb_float_div_16bit_seq;
   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0, divisor = '0;
   logic        busy, done;
   logic [15:0] quotient;
   logic [3:0]  flags;
   int          n_chk = 0, n_err = 0;

   float_div_16bit_seq dut (
      .CLK(CLK), .nRST(nRST), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .flags(flags)
   );

   always #5 CLK = ~CLK;

   logic [15:0] da [11] = '{16'h4000, 16'h3C00, 16'hC000, 16'h3C00, 16'h0000, 16'h7E00,
                            16'h7C01, 16'h7BFF, 16'h0400, 16'h0001, 16'h0200};
   logic [15:0] db [11] = '{16'h3C00, 16'h4200, 16'h3800, 16'h0000, 16'h0000, 16'h3C00,
                            16'h3C00, 16'h3800, 16'h4000, 16'h4000, 16'h3800};
   logic [15:0] dq [11] = '{16'h4000, 16'h3555, 16'hC400, 16'h7C00, 16'hFFFF, 16'hFFFF,
                            16'hFDFF, 16'h7C00, 16'h0200, 16'h0000, 16'h0400};
   logic [3:0]  df [11] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h8, 4'h2, 4'h0, 4'h1, 4'h0};
   int          dl [11] = '{15, 15, 15, 2, 2, 2, 2, 15, 15, 15, 15};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // exact reference: value = f * 2^g, largest half not above |a/b|
   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic [3:0] f, output bit sp);
      bit     s  = a[15] ^ b[15];
      bit     an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
      bit     bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
      bit     ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
      bit     bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
      bit     az = (a[14:0] == 0);
      bit     bz = (b[14:0] == 0);
      longint fa, fb, num, den, n;
      int     ga, gb, g, d;
      bit     found = 0;
      sp = 1;
      f  = 4'h0;
      q  = {s, 15'h7C00};
      if ((an && a[9]) || (bn && b[9])) q = 16'hFFFF;
      else if (an || bn) begin q = 16'hFDFF; f = 4'h8; end
      else if ((az && bz) || (ai && bi)) begin q = 16'hFFFF; f = 4'h8; end
      else if (bz && !ai) f = 4'h4;
      else if (ai) q = {s, 15'h7C00};
      else if (az || bi) q = {s, 15'h0000};
      else begin
         sp = 0;
         fa = (a[14:10] == 0) ? longint'(a[9:0]) : 1024 + longint'(a[9:0]);
         fb = (b[14:10] == 0) ? longint'(b[9:0]) : 1024 + longint'(b[9:0]);
         ga = (a[14:10] == 0) ? -24 : int'(a[14:10]) - 25;
         gb = (b[14:10] == 0) ? -24 : int'(b[14:10]) - 25;
         g  = ga - gb - 16;
         if ((g >= 0) ? ((fa << g) >= fb) : (fa >= (fb << -g))) begin
            q = {s, 15'h7C00};
            f = 4'h2;
         end else begin
            for (int k = 30; k >= 1 && !found; k--) begin
               d   = ga - gb - k + 25;
               num = (d >= 0) ? (fa << d) : fa;
               den = (d >= 0) ? fb : (fb << -d);
               n   = num / den;
               if (n >= 1024) begin
                  q     = {s, 5'(k), 10'(n - 1024)};
                  found = 1;
               end
            end
            if (!found) begin
               d   = ga - gb + 24;
               num = (d >= 0) ? (fa << d) : fa;
               den = (d >= 0) ? fb : (fb << -d);
               q   = {s, 5'd0, 10'(num / den)};
               f   = (num % den != 0) ? 4'h1 : 4'h0;
            end
         end
      end
   endfunction

   function automatic logic [15:0] rand_op();
      int sel = $urandom_range(0, 9);
      if (sel == 0) return 16'($urandom);
      if (sel == 1) return {1'($urandom), 5'd0, 10'($urandom)};
      if (sel == 2)
         case ($urandom_range(0, 6))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7C00;
            3:       return 16'hFC00;
            4:       return 16'h7E00;
            5:       return 16'h7C01;
            default: return 16'hFD00;
         endcase
      return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                         output logic [15:0] q, output logic [3:0] f, output int lat);
      bit busy_ok = 1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge CLK); #1;
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      lat = 0;
      while (lat < 40) begin
         if (!busy) busy_ok = 0;
         start = (pulse_at != 0) && (lat == pulse_at);
         @(posedge CLK); #1;
         lat++;
         if (done) break;
      end
      start = 1'b0;
      check("busy_during_op", 32'(busy_ok), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      q = quotient;
      f = flags;
   endtask

   task automatic do_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [3:0] ef, input int el, input int pulse);
      logic [15:0] q;
      logic [3:0]  f;
      int          lat;
      run_op(a, b, pulse, q, f, lat);
      check({tag, "_q"}, 32'(q), 32'(eq));
      check({tag, "_flags"}, 32'(f), 32'(ef));
      check({tag, "_latency"}, 32'(lat), 32'(el));
   endtask

   initial begin
      logic [15:0] ra, rb, eq;
      logic [3:0]  ef;
      bit          sp;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_q", 32'(quotient), 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      nRST = 1'b1;
      @(posedge CLK); #1;
      do_check("handshake", da[0], db[0], dq[0], df[0], dl[0], 5);
      @(posedge CLK); #1;
      check("ignored_start", 32'({busy, done}), 32'd0);
      for (int i = 1; i < 11; i++)
         do_check($sformatf("dir%0d", i), da[i], db[i], dq[i], df[i], dl[i], 0);
      dividend = 16'h4000;
      divisor  = 16'h3C00;
      start    = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (7) @(posedge CLK);
      #3 nRST = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_q", 32'(quotient), 32'd0);
      check("abort_flags", 32'(flags), 32'd0);
      repeat (2) @(posedge CLK);
      #3 nRST = 1'b1;
      @(posedge CLK); #1;
      model(16'h4400, 16'h4000, eq, ef, sp);
      do_check("post_reset", 16'h4400, 16'h4000, eq, ef, sp ? 2 : 15, 0);
      for (int i = 0; i < 250; i++) begin
         ra = rand_op();
         rb = rand_op();
         model(ra, rb, eq, ef, sp);
         do_check($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, eq, ef, sp ? 2 : 15, 0);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
